kb_uart_bridge: RTL

- Parametrised keyboard-to-serial bridge that generalises the single-byte key-to-UART path.
- Accepts byte strobes from the keyboard/key2ascii path and buffers them in a DEPTH-entry FIFO, so key bursts are not lost while a frame is in flight.
- Serialises each byte with configurable data width, parity and stop bits, using its own 16x-oversampled baud generator.
- Reports FIFO occupancy and a sticky overflow flag for the debug LEDs.

---
 rtl/kb_uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/kb_uart_bridge.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/kb_uart_pkg.sv
// Shared constants, FSM encoding and parity helper for the keyboard-to-UART bridge.
package kb_uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Baud ticks per serial bit.
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Parity bit for a zero-extended data word: XOR of the bits for even, inverted for odd.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop in the same cycle frees room for a push when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next pointer and occupancy values; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage is deliberately not reset; the cleared count makes stale entries unreachable.
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/kb_uart_bridge.sv
// Keyboard byte strobes are queued in a FIFO and serialised onto a UART line
// with configurable data width, parity and stop bits.
module kb_uart_bridge
    import kb_uart_pkg::*;
#(
    parameter int DIVISOR   = 163,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              key_data,
    input  logic                    key_valid,
    input  logic                    clr_ovf,
    output logic                    tx,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    localparam int CNT_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    // Baud generator
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic                 tick;

    // Transmitter
    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;

    // FIFO and overflow
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 ovf_q, ovf_d;
    logic                 drop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (key_valid),
        .wdata (key_data[DATA_BITS-1:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tick    = (baud_cnt_q == CNT_W'(DIVISOR - 1));
    assign bit_end = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

    // A push is lost only when full and the transmitter is not freeing a slot this cycle.
    assign drop = key_valid && fifo_full && !fifo_pop;

    // Free-running oversample counter; never restarted by the transmitter.
    always_comb begin
        baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    end

    // Baud counter register.
    always_ff @(posedge clk) begin
        if (!reset) baud_cnt_q <= '0;
        else        baud_cnt_q <= baud_cnt_d;
    end

    // Transmit FSM next state, shift register and registered line/busy values.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        fifo_pop   = 1'b0;
        tick_cnt_d = tick_cnt_q;
        if (tick) tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shreg_d    = fifo_rdata;
                    par_d      = parity_bit(8'(fifo_rdata), PARITY);
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) state_d = ST_IDLE;
                    else                                bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the state being entered so tx is a clean flop output.
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sticky overflow: a dropped push wins over a simultaneous clear.
    always_comb begin
        ovf_d = clr_ovf ? 1'b0 : ovf_q;
        if (drop) ovf_d = 1'b1;
    end

    // Transmitter and overflow registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule
